glb_proc_responder: RTL and testbench

GLB_PROC_RESPONDER -- requirements
Module: glb_proc_responder

---
 rtl/glb_proc_responder_pkg.sv | 23 ++
 rtl/glb_proc_mem.sv | 49 ++++
 rtl/glb_proc_responder.sv | 158 +++++++++++++++
 tb/tb_glb_proc_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_proc_responder_pkg.sv
// ---------------------------------------------------------------------------
// global_buffer_param
//   Shared constants for the global-buffer processor-side logic.
//   BANK_DATA_WIDTH  : processor data bus width in bits (multiple of 8)
//   GLB_ADDR_WIDTH   : processor byte-address width
//   BANK_BYTE_OFFSET : number of byte-offset address bits inside one bank word
//   OOR_CNT_WIDTH    : width of the out-of-range access counter
// ---------------------------------------------------------------------------
package global_buffer_param;

  localparam int BANK_DATA_WIDTH = 64;
  localparam int GLB_ADDR_WIDTH  = 19;
  localparam int OOR_CNT_WIDTH   = 16;

  // Byte-offset bit count for an arbitrary bus width.  Blocks that are
  // instantiated with a non-default width use this instead of the constant.
  function automatic int byteOffsetWidth(input int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

  localparam int BANK_BYTE_OFFSET = byteOffsetWidth(BANK_DATA_WIDTH);

endpackage

// File: rtl/glb_proc_mem.sv
// ---------------------------------------------------------------------------
// glb_proc_mem
//   Single-clock word storage with one byte-masked write port and one
//   registered read port.  Contents are never reset.
//   Ports:
//     clk       : clock
//     wrEn_i    : write enable
//     wrStrb_i  : per-byte write enable
//     wrAddr_i  : write word index
//     wrData_i  : write data
//     rdEn_i    : read enable (loads the read register)
//     rdAddr_i  : read word index
//     rdData_o  : registered read data, valid the cycle after rdEn_i
// ---------------------------------------------------------------------------
module glb_proc_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    wrEn_i,
  input  logic [DATA_WIDTH/8-1:0] wrStrb_i,
  input  logic [ADDR_WIDTH-1:0]   wrAddr_i,
  input  logic [DATA_WIDTH-1:0]   wrData_i,
  input  logic                    rdEn_i,
  input  logic [ADDR_WIDTH-1:0]   rdAddr_i,
  output logic [DATA_WIDTH-1:0]   rdData_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdData_q;

  // Write and read share one process so a same-cycle read of the word being
  // written sees the old contents (non-blocking update lands after the read).
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wrStrb_i[b]) begin
          mem_q[wrAddr_i][b*8 +: 8] <= wrData_i[b*8 +: 8];
        end
      end
    end
    if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/glb_proc_responder.sv
// ---------------------------------------------------------------------------
// glb_proc_responder
//   Processor-side responder for one global-buffer bank.  Accepts byte-masked
//   writes and fully pipelined reads; every read returns exactly RD_LATENCY
//   cycles after its request cycle, in order, with no back-pressure.
//   Accesses whose address has any bit set above the word index are out of
//   range: writes are dropped, reads respond with zero data.
//
//   Optional feature macro: GLB_PROC_OOR_CNT_EN
//     defined   -> oor_err (sticky) and oor_cnt (saturating 16-bit count of
//                  out-of-range requests) ports and logic are present.
//     undefined -> those ports and their logic are absent.
//
//   Ports:
//     clk, reset     : clock, asynchronous active-high reset
//     wr_en/strb/addr/data : write request
//     rd_en/rd_addr  : read request
//     rd_data        : read response data (zero when not valid)
//     rd_data_valid  : one-cycle response qualifier
//     oor_err        : sticky out-of-range flag (macro only)
//     oor_cnt        : out-of-range request count (macro only)
// ---------------------------------------------------------------------------
module glb_proc_responder #(
  parameter int BANK_DATA_WIDTH     = global_buffer_param::BANK_DATA_WIDTH,
  parameter int GLB_ADDR_WIDTH      = global_buffer_param::GLB_ADDR_WIDTH,
  parameter int MEM_WORD_ADDR_WIDTH = 10,
  parameter int RD_LATENCY          = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [BANK_DATA_WIDTH/8-1:0] wr_strb,
  input  logic [GLB_ADDR_WIDTH-1:0]    wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0]   wr_data,
  input  logic                         rd_en,
  input  logic [GLB_ADDR_WIDTH-1:0]    rd_addr,
  output logic [BANK_DATA_WIDTH-1:0]   rd_data,
  output logic                         rd_data_valid
`ifdef GLB_PROC_OOR_CNT_EN
  ,
  output logic                         oor_err,
  output logic [15:0]                  oor_cnt
`endif
);

  import global_buffer_param::*;

  localparam int ByteOffset = byteOffsetWidth(BANK_DATA_WIDTH);
  localparam int HiLsb      = ByteOffset + MEM_WORD_ADDR_WIDTH;

  logic [MEM_WORD_ADDR_WIDTH-1:0] wrIdx;
  logic [MEM_WORD_ADDR_WIDTH-1:0] rdIdx;
  logic                           wrOor;
  logic                           rdOor;
  logic                           memWrEn;
  logic [BANK_DATA_WIDTH-1:0]     memRdData;
  logic [BANK_DATA_WIDTH-1:0]     respData;
  logic                           unusedAddrBits;

  // Byte-offset bits select a byte inside the word and play no part here.
  assign unusedAddrBits = ^{wr_addr[ByteOffset-1:0], rd_addr[ByteOffset-1:0]};

  assign wrIdx   = wr_addr[ByteOffset +: MEM_WORD_ADDR_WIDTH];
  assign rdIdx   = rd_addr[ByteOffset +: MEM_WORD_ADDR_WIDTH];
  assign wrOor   = |wr_addr[GLB_ADDR_WIDTH-1:HiLsb];
  assign rdOor   = |rd_addr[GLB_ADDR_WIDTH-1:HiLsb];
  assign memWrEn = wr_en & ~wrOor;

  // The storage read register forms pipeline stage 0.  Out-of-range reads
  // still read (an aliased word) but the result is masked at the output.
  glb_proc_mem #(
    .DATA_WIDTH (BANK_DATA_WIDTH),
    .ADDR_WIDTH (MEM_WORD_ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .wrEn_i   (memWrEn),
    .wrStrb_i (wr_strb),
    .wrAddr_i (wrIdx),
    .wrData_i (wr_data),
    .rdEn_i   (rd_en),
    .rdAddr_i (rdIdx),
    .rdData_o (memRdData)
  );

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] oor_q, oor_d;

  // Shift the (valid, out-of-range) tag one stage per cycle.
  always_comb begin
    vld_d    = '0;
    oor_d    = '0;
    vld_d[0] = rd_en;
    oor_d[0] = rdOor;
    for (int s = 1; s < RD_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      oor_d[s] = oor_q[s-1];
    end
  end

  // Reset flushes every in-flight read so none responds afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      oor_q <= '0;
    end else begin
      vld_q <= vld_d;
      oor_q <= oor_d;
    end
  end

  // Data follows its tag through stages 1..RD_LATENCY-1; it needs no reset
  // because the output is gated by the tag.
  if (RD_LATENCY == 1) begin : g_direct
    assign respData = memRdData;
  end else begin : g_pipe
    logic [BANK_DATA_WIDTH-1:0] dataPipe_q [RD_LATENCY-1];
    always_ff @(posedge clk) begin
      dataPipe_q[0] <= memRdData;
      for (int s = 1; s < RD_LATENCY - 1; s++) begin
        dataPipe_q[s] <= dataPipe_q[s-1];
      end
    end
    assign respData = dataPipe_q[RD_LATENCY-2];
  end

  assign rd_data_valid = vld_q[RD_LATENCY-1];
  assign rd_data       = (vld_q[RD_LATENCY-1] && !oor_q[RD_LATENCY-1]) ? respData : '0;

`ifdef GLB_PROC_OOR_CNT_EN
  logic        oorErr_q, oorErr_d;
  logic [15:0] oorCnt_q, oorCnt_d;
  logic [1:0]  oorInc;
  logic [16:0] oorSum;

  // Read and write are counted separately; the 17th sum bit detects
  // overflow so the count sticks at all-ones.
  always_comb begin
    oorInc   = {1'b0, rd_en & rdOor} + {1'b0, wr_en & wrOor};
    oorSum   = {1'b0, oorCnt_q} + {15'b0, oorInc};
    oorCnt_d = oorSum[16] ? 16'hFFFF : oorSum[15:0];
    oorErr_d = oorErr_q | (oorInc != 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oorErr_q <= 1'b0;
      oorCnt_q <= '0;
    end else begin
      oorErr_q <= oorErr_d;
      oorCnt_q <= oorCnt_d;
    end
  end

  assign oor_err = oorErr_q;
  assign oor_cnt = oorCnt_q;
`endif

endmodule

// File: tb/tb_glb_proc_responder.sv
// ---------------------------------------------------------------------------
// tb_glb_proc_responder
//   Directed bench for glb_proc_responder with a word-level reference model
//   and literal expectations for the headline scenarios.
// ---------------------------------------------------------------------------
module tb_glb_proc_responder;

  localparam int DW  = 64;
  localparam int AW  = 19;
  localparam int MW  = 10;
  localparam int LAT = 2;
  localparam int SB  = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [SB-1:0] wr_strb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
`ifdef GLB_PROC_OOR_CNT_EN
  logic          oor_err;
  logic [15:0]   oor_cnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  glb_proc_responder #(
    .BANK_DATA_WIDTH     (DW),
    .GLB_ADDR_WIDTH      (AW),
    .MEM_WORD_ADDR_WIDTH (MW),
    .RD_LATENCY          (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_strb       (wr_strb),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid)
`ifdef GLB_PROC_OOR_CNT_EN
    ,
    .oor_err       (oor_err),
    .oor_cnt       (oor_cnt)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            known;
  } resp_t;

  resp_t         expQ[$];
  logic [DW-1:0] modelMem[int];
  logic [SB-1:0] modelKnown[int];
  int            edgeN  = 0;
  int            expCnt = 0;
  bit            expErr = 1'b0;
  logic [DW-1:0] gotData[$];
  int            gotEdge[$];

  function automatic bit inRange(input logic [AW-1:0] a);
    return (int'(a) / (8 * (1 << MW))) == 0;
  endfunction

  function automatic int wordOf(input logic [AW-1:0] a);
    return (int'(a) / 8) % (1 << MW);
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference model: at each sampling edge record what a read must return
  // and when, then apply the write (so same-cycle reads see old data), and
  // tally out-of-range requests.
  always @(posedge clk or posedge reset) begin
    resp_t         r;
    int            w;
    int            n;
    logic [DW-1:0] cur;
    logic [SB-1:0] kn;
    if (reset) begin
      expQ.delete();
      expCnt = 0;
      expErr = 1'b0;
    end else begin
      edgeN++;
      if (rd_en) begin
        r.due   = edgeN + LAT - 1;
        r.data  = '0;
        r.known = 1'b1;
        if (inRange(rd_addr)) begin
          w = wordOf(rd_addr);
          if (modelKnown.exists(w) && modelKnown[w] == '1) r.data = modelMem[w];
          else r.known = 1'b0;
        end
        expQ.push_back(r);
      end
      if (wr_en && inRange(wr_addr)) begin
        w   = wordOf(wr_addr);
        cur = modelMem.exists(w) ? modelMem[w] : '0;
        kn  = modelKnown.exists(w) ? modelKnown[w] : '0;
        for (int b = 0; b < SB; b++) begin
          if (wr_strb[b]) begin
            cur[b*8 +: 8] = wr_data[b*8 +: 8];
            kn[b] = 1'b1;
          end
        end
        modelMem[w]   = cur;
        modelKnown[w] = kn;
      end
      n = 0;
      if (rd_en && !inRange(rd_addr)) n++;
      if (wr_en && !inRange(wr_addr)) n++;
      expCnt = (expCnt + n > 65535) ? 65535 : expCnt + n;
      if (n != 0) expErr = 1'b1;
    end
  end

  // Per-cycle compare against the model, and capture of every response for
  // the literal checks in the stimulus.
  always @(negedge clk) begin
    bit            ev;
    logic [DW-1:0] ed;
    bit            kn;
    ev = 1'b0;
    ed = '0;
    kn = 1'b1;
    if (expQ.size() > 0 && expQ[0].due == edgeN) begin
      ev = 1'b1;
      ed = expQ[0].data;
      kn = expQ[0].known;
      void'(expQ.pop_front());
    end
    checkOutput("model_valid", {63'b0, rd_data_valid}, {63'b0, ev});
    if (kn) checkOutput("model_data", rd_data, ed);
`ifdef GLB_PROC_OOR_CNT_EN
    checkOutput("model_oor_cnt", {48'b0, oor_cnt}, DW'(expCnt));
    checkOutput("model_oor_err", {63'b0, oor_err}, {63'b0, expErr});
`endif
    if (rd_data_valid) begin
      gotData.push_back(rd_data);
      gotEdge.push_back(edgeN);
    end
  end

  task automatic applyStimulus(input logic wen, input logic [SB-1:0] strb,
                               input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                               input logic ren, input logic [AW-1:0] raddr);
    @(negedge clk);
    wr_en   = wen;
    wr_strb = strb;
    wr_addr = waddr;
    wr_data = wdata;
    rd_en   = ren;
    rd_addr = raddr;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic clearGot();
    gotData.delete();
    gotEdge.delete();
  endtask

  task automatic readExpect(input string name, input logic [AW-1:0] a,
                            input logic [DW-1:0] lit);
    clearGot();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, a);
    idle(5);
    checkOutput({name, "_count"}, DW'(gotData.size()), DW'(1));
    if (gotData.size() > 0) checkOutput({name, "_data"}, gotData[0], lit);
  endtask

  // Directed scenarios with hand-computed literal results.
  initial begin
    int issueEdge;
    reset = 1'b1;
    wr_en = 1'b0; wr_strb = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", {63'b0, rd_data_valid}, '0);
    checkOutput("reset_data", rd_data, '0);
    reset = 1'b0;
    idle(2);

    // Full-word write then read, with latency pinned.
    applyStimulus(1'b1, 8'hFF, 19'h40, 64'h1122334455667788, 1'b0, '0);
    clearGot();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 19'h40);
    issueEdge = edgeN;
    idle(5);
    checkOutput("full_write_count", DW'(gotData.size()), DW'(1));
    if (gotData.size() > 0) begin
      checkOutput("full_write_data", gotData[0], 64'h1122334455667788);
      checkOutput("read_latency", DW'(gotEdge[0] - issueEdge), DW'(LAT));
    end

    // Low-half strobe write.
    applyStimulus(1'b1, 8'h0F, 19'h40, {8{8'hAA}}, 1'b0, '0);
    readExpect("partial_strb", 19'h40, 64'h11223344AAAAAAAA);

    // All-zero strobe changes nothing; byte-offset bits are ignored.
    applyStimulus(1'b1, 8'h00, 19'h40, {8{8'hFF}}, 1'b0, '0);
    readExpect("zero_strb", 19'h47, 64'h11223344AAAAAAAA);

    // Last in-range word.
    applyStimulus(1'b1, 8'hFF, 19'h1FF8, 64'hCAFEF00D12345678, 1'b0, '0);
    readExpect("top_word", 19'h1FF8, 64'hCAFEF00D12345678);

    // Same-cycle read/write returns old data, next read returns new.
    applyStimulus(1'b1, 8'hFF, 19'h80, 64'h0123456789ABCDEF, 1'b0, '0);
    clearGot();
    applyStimulus(1'b1, 8'hFF, 19'h80, {8{8'h5A}}, 1'b1, 19'h80);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 19'h80);
    idle(5);
    checkOutput("rbw_count", DW'(gotData.size()), DW'(2));
    if (gotData.size() == 2) begin
      checkOutput("rbw_old", gotData[0], 64'h0123456789ABCDEF);
      checkOutput("rbw_new", gotData[1], {8{8'h5A}});
    end

    // Back-to-back reads respond on consecutive cycles, in order.
    applyStimulus(1'b1, 8'hFF, 19'h00, 64'h000000000000A000, 1'b0, '0);
    applyStimulus(1'b1, 8'hFF, 19'h08, 64'h000000000000B008, 1'b0, '0);
    applyStimulus(1'b1, 8'hFF, 19'h10, 64'h000000000000C010, 1'b0, '0);
    clearGot();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 19'h00);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 19'h08);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 19'h10);
    idle(5);
    checkOutput("b2b_count", DW'(gotData.size()), DW'(3));
    if (gotData.size() == 3) begin
      checkOutput("b2b_first", gotData[0], 64'h000000000000A000);
      checkOutput("b2b_second", gotData[1], 64'h000000000000B008);
      checkOutput("b2b_third", gotData[2], 64'h000000000000C010);
      checkOutput("b2b_spacing", DW'(gotEdge[2] - gotEdge[0]), DW'(2));
    end

    // Out-of-range read and write in the same cycle.
    clearGot();
    applyStimulus(1'b1, 8'hFF, 19'h2000, {8{8'hEE}}, 1'b1, 19'h2000);
    idle(5);
    checkOutput("oor_rd_count", DW'(gotData.size()), DW'(1));
    if (gotData.size() > 0) checkOutput("oor_rd_data", gotData[0], '0);
`ifdef GLB_PROC_OOR_CNT_EN
    checkOutput("oor_cnt_two", {48'b0, oor_cnt}, DW'(2));
    checkOutput("oor_err_set", {63'b0, oor_err}, DW'(1));
`endif
    readExpect("oor_mem_unchanged", 19'h00, 64'h000000000000A000);

    // Reset one cycle after a read discards it.
    clearGot();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 19'h40);
    @(negedge clk);
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset_imm_valid", {63'b0, rd_data_valid}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(6);
    checkOutput("reset_flush", DW'(gotData.size()), DW'(0));
`ifdef GLB_PROC_OOR_CNT_EN
    checkOutput("reset_oor_cnt", {48'b0, oor_cnt}, '0);
    checkOutput("reset_oor_err", {63'b0, oor_err}, '0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

endmodule
